// File: rtl/sample_interpolator.sv
// Linear-interpolating upsampler: each accepted sample yields 2^RATIO_LOG2 outputs
// ramping from the previous sample toward the new one, with valid/ready on both sides.
module sample_interpolator #(
  parameter int DATA_WIDTH = 12,
  parameter int RATIO_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int ACC_WIDTH = DATA_WIDTH + RATIO_LOG2 + 1;
  localparam logic [RATIO_LOG2-1:0] K_LAST = {RATIO_LOG2{1'b1}};
  localparam logic [RATIO_LOG2-1:0] K_ONE  = RATIO_LOG2'(1'b1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [DATA_WIDTH-1:0] curr_r;
  logic [DATA_WIDTH:0]   delta_r;
  logic [ACC_WIDTH-1:0]  acc_r;
  logic [RATIO_LOG2-1:0] k_r;

  logic last_step_s;
  logic accept_s;
  logic xfer_s;
  logic in_ready_s;
  logic out_valid_s;

  assign last_step_s = (k_r == K_LAST);
  assign accept_s    = in_valid && in_ready_s;
  assign xfer_s      = out_valid_s && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: a new accept always (re)starts a burst.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (accept_s) begin
          state_s = EMIT;
        end else if (xfer_s && last_step_s) begin
          state_s = IDLE;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode; in_ready deliberately looks through out_ready on the last step.
  always_comb begin
    out_valid_s = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
      end
      EMIT: begin
        out_valid_s = 1'b1;
        in_ready_s  = last_step_s && out_ready;
      end
      default: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b0;
      end
    endcase
  end

  // Ramp datapath: accept reloads the ramp and takes priority over a same-cycle step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_r  <= '0;
      delta_r <= '0;
      acc_r   <= '0;
      k_r     <= '0;
    end else if (accept_s) begin
      acc_r   <= {curr_r[DATA_WIDTH-1], curr_r, {RATIO_LOG2{1'b0}}};
      delta_r <= {in_data[DATA_WIDTH-1], in_data} - {curr_r[DATA_WIDTH-1], curr_r};
      curr_r  <= in_data;
      k_r     <= '0;
    end else if (xfer_s) begin
      acc_r   <= acc_r + {{RATIO_LOG2{delta_r[DATA_WIDTH]}}, delta_r};
      k_r     <= k_r + K_ONE;
    end else begin
      acc_r   <= acc_r;
      k_r     <= k_r;
    end
  end

  // Dropping the low RATIO_LOG2 bits is the arithmetic floor divide by R.
  assign out_data  = acc_r[RATIO_LOG2 +: DATA_WIDTH];
  assign out_valid = out_valid_s;
  assign in_ready  = in_ready_s;

endmodule
